// File: rtl/npu8_pkg.sv
// npu8 shared types and constants.
// Used by the q_out byte packer and its FIFO.
package npu8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FINISH = 2'd3
  } pack_state_t;

  localparam logic [15:0] VMIN_INIT = 16'h7FFF;
  localparam logic [15:0] VMAX_INIT = 16'h8000;

  localparam int FIFO_DEPTH_DEF = 4;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 16;

endpackage

// File: rtl/q_out_pack8_if.sv
// Word-write bus from the packer to the sink.
// Valid/ready handshake, data held while stalled.
interface q_out_pack8_if;
  logic        WR_VALID;
  logic        WR_READY;
  logic [31:0] WR_DATA;
  logic [15:0] WR_ADDR;

  modport master (
    output WR_VALID,
    output WR_DATA,
    output WR_ADDR,
    input  WR_READY
  );

  modport slave (
    input  WR_VALID,
    input  WR_DATA,
    input  WR_ADDR,
    output WR_READY
  );
endinterface

// File: rtl/q_fifo32.sv
// Synchronous FIFO for packed words plus their address.
// Head entry is visible on rdata whenever not empty.
module q_fifo32 #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic             CLK,
  input  logic             RESET_X,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_pop;
  logic             do_push;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  // A full FIFO still takes a word if the head leaves this cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rp[AW-1:0]];

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp[AW-1:0]] <= wdata;
        wp <= wp + 1'b1;
      end
      if (do_pop)
        rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/q_out_pack8.sv
// Packs quantized bytes into 32-bit little-endian words,
// tracks the signed range, and streams words to memory.
module q_out_pack8
  import npu8_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic          CLK,
  input  logic          RESET_X,
  input  logic          START,
  input  logic [15:0]   VEC_LEN,
  input  logic [15:0]   BASE_ADDR,
  input  logic          IN_EN,
  input  logic [7:0]    IN_DATA,
  input  logic [15:0]   IN_MIN,
  input  logic [15:0]   IN_MAX,
  q_out_pack8_if.master wr,
  output logic          BUSY,
  output logic          DONE,
  output logic [15:0]   VEC_MIN,
  output logic [15:0]   VEC_MAX,
  output logic          OVERFLOW
);

  localparam int EW = WORD_W + ADDR_W;

  pack_state_t       state;
  logic [15:0]       len;
  logic [15:0]       base;
  logic [15:0]       cnt;
  logic [15:0]       widx;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] word;
  logic [EW-1:0]     f_in;
  logic [EW-1:0]     f_out;
  logic              take;
  logic              last;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  assign take = (state == ST_RUN) && IN_EN && (cnt < len);
  assign last = (cnt + 16'd1) == len;
  // Upper lanes of acc are always zero, so OR places the new byte
  assign word = acc |
    ({24'd0, IN_DATA} << {cnt[1:0], 3'b000});
  assign push = take && ((cnt[1:0] == 2'd3) || last);
  assign f_in = {base + widx, word};

  assign pop         = wr.WR_VALID && wr.WR_READY;
  assign wr.WR_VALID = !empty;
  assign wr.WR_DATA  = f_out[WORD_W-1:0];
  assign wr.WR_ADDR  = f_out[EW-1:WORD_W];

  q_fifo32 #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_X (RESET_X),
    .push    (push),
    .pop     (pop),
    .wdata   (f_in),
    .rdata   (f_out),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      state    <= ST_IDLE;
      len      <= '0;
      base     <= '0;
      cnt      <= '0;
      widx     <= '0;
      acc      <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      VEC_MIN  <= VMIN_INIT;
      VEC_MAX  <= VMAX_INIT;
      OVERFLOW <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (START) begin
            len      <= VEC_LEN;
            base     <= BASE_ADDR;
            cnt      <= '0;
            widx     <= '0;
            acc      <= '0;
            VEC_MIN  <= VMIN_INIT;
            VEC_MAX  <= VMAX_INIT;
            OVERFLOW <= 1'b0;
            BUSY     <= 1'b1;
            state    <= (VEC_LEN == 16'd0) ?
                        ST_FLUSH : ST_RUN;
          end
        end
        ST_RUN: begin
          if (take) begin
            cnt <= cnt + 16'd1;
            acc <= push ? '0 : word;
            if (push)
              widx <= widx + 16'd1;
            if ($signed(IN_MIN) < $signed(VEC_MIN))
              VEC_MIN <= IN_MIN;
            if ($signed(IN_MAX) > $signed(VEC_MAX))
              VEC_MAX <= IN_MAX;
            if (last)
              state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (empty) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= ST_FINISH;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
      if (push && full && !pop)
        OVERFLOW <= 1'b1;
    end
  end

endmodule

// File: doc/q_out_pack8.md
Q_OUT_PACK8 -- requirements
Module: q_out_pack8

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the packed-word FIFO depth in 32-bit entries (power of 2, minimum 2).
REQ-002 SHALL have port CLK, input, 1 bit, the clock; all logic is on the rising edge.
REQ-003 SHALL have port RESET_X, input, 1 bit, the reset: asynchronous, active-low.
REQ-004 SHALL have port START, input, 1 bit, a single-cycle pulse that begins one vector.
REQ-005 SHALL have port VEC_LEN, input, 16 bits, the number of bytes in the vector, sampled on START.
REQ-006 SHALL have port BASE_ADDR, input, 16 bits, the first word address, sampled on START.
REQ-007 SHALL have port IN_EN, input, 1 bit, the byte-valid strobe from the upstream q_mul stage; it has no backpressure.
REQ-008 SHALL have port IN_DATA, input, 8 bits, the quantized result byte.
REQ-009 SHALL have ports IN_MIN and IN_MAX, input, 16 bits each, the per-sample range values, signed two's complement.
REQ-010 SHALL have port WR_VALID, output, 1 bit, the word-write request.
REQ-011 SHALL have port WR_READY, input, 1 bit, the sink accept; a transfer is WR_VALID and WR_READY in the same cycle.
REQ-012 SHALL have ports WR_DATA, output, 32 bits, and WR_ADDR, output, 16 bits, the packed word and its address.
REQ-013 SHALL have port BUSY, output, 1 bit, high from the cycle after an accepted START until DONE.
REQ-014 SHALL have port DONE, output, 1 bit, a single-cycle pulse after the last word transfers.
REQ-015 SHALL have ports VEC_MIN and VEC_MAX, output, 16 bits each, the signed running min of IN_MIN and max of IN_MAX.
REQ-016 SHALL have port OVERFLOW, output, 1 bit, sticky: a completed word was dropped because the FIFO was full.

Function
REQ-017 SHALL implement states IDLE, RUN, FLUSH and FINISH; START is accepted only in IDLE and is ignored otherwise.
REQ-018 SHALL, on START in IDLE: latch VEC_LEN and BASE_ADDR, clear the byte count, set VEC_MIN=16'h7FFF and VEC_MAX=16'h8000, clear OVERFLOW, and go to RUN (FLUSH if VEC_LEN=0).
REQ-019 SHALL, in RUN, take each IN_EN byte while the count is below VEC_LEN; it ignores IN_EN in every other state and after VEC_LEN bytes.
REQ-020 SHALL pack bytes little-endian: byte k goes to WR_DATA[8*(k%4)+7 : 8*(k%4)].
REQ-021 SHALL push a completed word into the FIFO at the end of the cycle its 4th byte, or the vector's final byte, is taken; unused upper bytes are zero.
REQ-022 SHALL raise WR_VALID at the earliest the cycle after the push (1-cycle latency).
REQ-023 SHALL allow a push into a full FIFO only if a pop occurs in the same cycle; otherwise the word is dropped and OVERFLOW is set.
REQ-024 SHALL hold WR_DATA and WR_ADDR stable while WR_VALID=1 and WR_READY=0.
REQ-025 SHALL use WR_ADDR = BASE_ADDR + the index of the word, where the index counts pushed or dropped words, wrapping modulo 2^16.
REQ-026 SHALL update VEC_MIN/VEC_MAX with signed compare on every byte taken.
REQ-027 SHALL go RUN->FLUSH when the count reaches VEC_LEN, FLUSH->FINISH when the FIFO is empty, and FINISH->IDLE after one cycle with DONE=1.
REQ-028 SHALL keep VEC_MIN, VEC_MAX and OVERFLOW valid after DONE until the next START.

Reset
REQ-029 SHALL, under RESET_X=0, asynchronously force: state IDLE, FIFO empty, WR_VALID=0, WR_DATA=0, WR_ADDR=0, BUSY=0, DONE=0, VEC_MIN=16'h7FFF, VEC_MAX=16'h8000, OVERFLOW=0.
REQ-030 SHALL, on reset mid-vector, discard all buffered bytes and words, with no DONE issued.

Structure
REQ-031 SHALL place the state encoding, the min/max init constants and the default FIFO_DEPTH in the shared npu8 package.
REQ-032 SHALL implement the FIFO as one sub-module, q_fifo32, a synchronous FIFO with full, empty, push and pop.

Verification
REQ-033 SHALL cover: VEC_LEN=8, BASE_ADDR=16'h0100, bytes 01..08 with WR_READY=1 -> words 32'h04030201 at 16'h0100 and 32'h08070605 at 16'h0101, then DONE.
REQ-034 SHALL cover: VEC_LEN=5, bytes AA BB CC DD EE -> second word 32'h000000EE, 2 transfers, then DONE.
REQ-035 SHALL cover: VEC_LEN=0 -> no WR_VALID, DONE within 3 cycles, VEC_MIN=16'h7FFF, VEC_MAX=16'h8000.
REQ-036 SHALL cover: WR_READY=0 while 24 bytes stream, FIFO_DEPTH=4 -> 4 words held, OVERFLOW=1, WR_ADDR of the first surviving word after the gap = BASE+6.
REQ-037 SHALL cover: IN_MIN -3,5,-7 and IN_MAX 2,9,1 -> VEC_MIN=16'hFFF9, VEC_MAX=16'h0009.
REQ-038 SHALL cover: RESET_X low during RUN, then a new START -> no stale words, first word at the new BASE_ADDR.
